unsigned_8x8_prod_acc: RTL and testbench
========================================

UNSIGNED_8X8_PROD_ACC -- requirements
Module: unsigned_8x8_prod_acc

Interface
REQ-001 SHALL have parameter N_TERMS, default 16, meaning the maximum number of products per accumulation (legal range 2..256).
REQ-002 SHALL have parameter PROD_W, default 16, meaning the width of the incoming unsigned product from the 8x8 approximate multiplier stage.
REQ-003 SHALL have derived localparam ACC_W = PROD_W + clog2(N_TERMS), which is 20 at the defaults.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a product beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 SHALL have port in_prod, input, PROD_W bits: the unsigned product z from the upstream multiplier.
REQ-009 SHALL have port in_last, input, 1 bit: the beat is the final term of the current accumulation.
REQ-010 SHALL have port clear, input, 1 bit: synchronously discards the partial accumulation.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-013 SHALL have port out_sum, output, ACC_W bits: the unsigned sum of the accepted products.
REQ-014 SHALL have port out_count, output, 9 bits: the number of terms in out_sum (1..N_TERMS).

Function
REQ-015 SHALL implement three states: IDLE (no partial sum), ACC (partial sum with count >= 1), and HOLD (result presented).
REQ-016 SHALL define a beat as accepted when in_valid && in_ready at a rising clock edge.
REQ-017 SHALL drive in_ready = 1 in IDLE and ACC when clear = 0; SHALL drive in_ready = 0 in HOLD and whenever clear = 1.
REQ-018 SHALL, on an accepted non-final beat: acc <= acc + zero-extended in_prod; cnt <= cnt + 1; IDLE->ACC.
REQ-019 SHALL treat a beat as final when in_last = 1 or cnt == N_TERMS-1.
REQ-020 SHALL, on a final beat: out_sum <= acc + in_prod; out_count <= cnt + 1; acc <= 0; cnt <= 0; go to HOLD; out_valid = 1 on the next cycle (latency of 1 cycle from the final beat).
REQ-021 SHALL never wrap the accumulation, since ACC_W is sized for N_TERMS maximum products.
REQ-022 SHALL, in HOLD, keep out_valid, out_sum and out_count stable until out_ready = 1; on that edge go to IDLE and set out_valid = 0, with in_ready = 1 from the following cycle.
REQ-023 SHALL, when clear = 1 in IDLE or ACC, set acc <= 0 and cnt <= 0 and go to IDLE; a concurrent in_valid beat is not accepted.
REQ-024 SHALL ignore clear in HOLD; the presented result is neither altered nor dropped.
REQ-025 SHALL treat in_valid with in_prod = 0 as a legitimate term that increments cnt.
REQ-026 SHALL hold out_sum and out_count at their last values when out_valid = 0; they are don't-care to consumers.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force state = IDLE, acc = 0, cnt = 0, out_valid = 0, out_sum = 0 and out_count = 0, independent of clk.
REQ-028 SHALL hold in_ready = 0 while rst_n = 0 and drive in_ready = 1 on the first clock edge after release.
REQ-029 SHALL, on a reset asserted mid-ACC or mid-HOLD, lose the partial or presented result without emitting it.

Structure
REQ-030 SHALL place the state enum (IDLE/ACC/HOLD) and an ACC_W width function in the shared package unsigned_mult_pkg.
REQ-031 SHALL implement the term counter plus final-beat detect as sub-module prod_acc_term_cnt; the datapath and FSM SHALL stay in the top module.
REQ-032 SHALL not instantiate the multiplier; in_prod arrives from the upstream multiplier stage.

Verification
REQ-033 SHALL verify full run: 16 beats of in_prod = 0xFFFF, in_last = 0, out_ready = 1 -> one cycle after beat 16, out_valid = 1, out_sum = 0xFFFF0, out_count = 16.
REQ-034 SHALL verify early last: beats 10, 20, 30 with in_last on the third -> out_sum = 60, out_count = 3.
REQ-035 SHALL verify backpressure: hold out_ready = 0 for 5 cycles in HOLD with in_valid = 1 -> out_sum stable, in_ready = 0, no beat consumed; then out_ready = 1 -> IDLE, and the next beat is accepted one cycle later.
REQ-036 SHALL verify clear: beats 5, 9, then clear = 1 with in_valid = 1, then a beat of 7 with in_last -> out_sum = 7, out_count = 1.
REQ-037 SHALL verify clear in HOLD: result 60 presented, pulse clear -> out_sum still 60 and out_valid still 1.
REQ-038 SHALL verify reset: rst_n = 0 mid-ACC after 3 beats, with no clock edge -> out_valid = 0 and in_ready = 0 immediately; after release, 2 beats of 4 with in_last -> out_sum = 8.

Source files
------------

// File: rtl/unsigned_mult_pkg.sv
// Shared definitions for the unsigned 8x8 product accumulator.
//   acc_state_e : accumulator FSM states (idle, accumulating, result held)
//   CountW      : width of the term counter / out_count (holds 1..256)
//   acc_width() : accumulator width that cannot overflow for n_terms products
package unsigned_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StHold = 2'd2
  } acc_state_e;

  localparam int unsigned CountW = 9;

  function automatic int unsigned acc_width(input int unsigned prod_w,
                                            input int unsigned n_terms);
    return prod_w + $clog2(n_terms);
  endfunction

endpackage

// File: rtl/prod_acc_term_cnt.sv
// Term counter with final-beat detection for the product accumulator.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : discard the running count
//   accept_i : a beat is accepted this cycle
//   last_i   : the offered beat is flagged as the last term
//   cnt_o    : terms accepted so far in the current accumulation
//   final_o  : the offered beat closes the accumulation
module prod_acc_term_cnt
  import unsigned_mult_pkg::*;
#(
  parameter int unsigned N_TERMS = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic              last_i,
  output logic [CountW-1:0] cnt_o,
  output logic              final_o
);

  logic [CountW-1:0] cnt_q, cnt_d;

  // A beat is final when flagged, or when it would be the N_TERMS-th term.
  assign final_o = last_i || (cnt_q == CountW'(N_TERMS - 1));
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept_i) begin
      cnt_d = final_o ? '0 : cnt_q + CountW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unsigned_8x8_prod_acc.sv
// Accumulates a stream of unsigned products from an upstream 8x8 multiplier
// and presents the sum plus term count with a valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : product beat handshake
//   in_prod              : unsigned product (PROD_W bits)
//   in_last              : beat is the final term of this accumulation
//   clear                : discard the partial sum (ignored while a result is held)
//   out_valid/out_ready  : result handshake
//   out_sum, out_count   : accumulated sum and number of terms (1..N_TERMS)
module unsigned_8x8_prod_acc
  import unsigned_mult_pkg::*;
#(
  parameter int unsigned N_TERMS = 16,
  parameter int unsigned PROD_W  = 16,
  localparam int unsigned ACC_W  = acc_width(PROD_W, N_TERMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [8:0]        out_count
);

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic [CountW-1:0] out_count_q, out_count_d;
  logic              rdy_en_q;
  logic              accept;
  logic              is_final;
  logic [CountW-1:0] cnt;
  logic [ACC_W-1:0]  sum;

  // rdy_en_q keeps in_ready low through reset and until the first edge after it.
  assign in_ready  = rdy_en_q && (state_q != StHold) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign sum       = acc_q + ACC_W'(in_prod);

  prod_acc_term_cnt #(
    .N_TERMS (N_TERMS)
  ) u_term_cnt (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear && (state_q != StHold)),
    .accept_i (accept),
    .last_i   (in_last),
    .cnt_o    (cnt),
    .final_o  (is_final)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (clear) begin
          acc_d   = '0;
          state_d = StIdle;
        end else if (accept) begin
          if (is_final) begin
            out_sum_d   = sum;
            out_count_d = cnt + CountW'(1);
            acc_d       = '0;
            state_d     = StHold;
          end else begin
            acc_d   = sum;
            state_d = StAcc;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unsigned_8x8_prod_acc.sv
module tb_unsigned_8x8_prod_acc;

  localparam int NT = 16;

  typedef struct {
    logic [19:0] sum;
    logic [8:0]  count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] out_sum;
  logic [8:0]  out_count;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_rdy = 1'b0;

  exp_t        exp_q[$];
  logic [15:0] terms[$];

  always #5 clk = ~clk;

  unsigned_8x8_prod_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted terms, emit (sum, count) on a closing beat.
  task automatic model_accept(input logic [15:0] p, input bit l);
    exp_t e;
    terms.push_back(p);
    if (l || terms.size() == NT) begin
      e.sum = '0;
      foreach (terms[i]) e.sum += 20'(terms[i]);
      e.count = 9'(terms.size());
      exp_q.push_back(e);
      terms.delete();
    end
  endtask

  // Offer one beat; returns how many extra cycles it waited for in_ready.
  task automatic beat(input logic [15:0] p, input bit l, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
    else model_accept(p, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'($urandom);
    @(negedge clk);
    check("ready_low_on_clear", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    if (!out_valid) terms.delete();
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop expected result whenever a result transfer is about to happen,
  // and require a stalled result to stay put.
  bit          prev_hold = 1'b0;
  logic [19:0] prev_sum;
  logic [8:0]  prev_cnt;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum_stable", 32'(out_sum), 32'(prev_sum));
        check("hold_cnt_stable", 32'(out_count), 32'(prev_cnt));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(e.sum));
          check("out_count", 32'(out_count), 32'(e.count));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_cnt  = out_count;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(in_ready), 32'd1);

    // Full run of N_TERMS maximum products.
    for (int i = 0; i < NT; i++) beat(16'hFFFF, 1'b0, w);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_sum", 32'(out_sum), 32'hFFFF0);
    check("full_count", 32'(out_count), 32'd16);
    drain();

    // Early last.
    beat(16'd10, 1'b0, w);
    beat(16'd20, 1'b0, w);
    beat(16'd30, 1'b1, w);
    check("early_sum", 32'(out_sum), 32'd60);
    check("early_count", 32'(out_count), 32'd3);
    drain();

    // Backpressure with a beat waiting.
    out_ready = 1'b0;
    beat(16'd10, 1'b0, w);
    beat(16'd20, 1'b0, w);
    beat(16'd30, 1'b1, w);
    in_valid = 1'b1;
    in_prod  = 16'd99;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(out_sum), 32'd60);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    beat(16'd99, 1'b1, w);
    check("bp_accept_latency", 32'(w), 32'd1);
    drain();

    // Clear in the middle of an accumulation; zero product is a real term.
    beat(16'd5, 1'b0, w);
    beat(16'd9, 1'b0, w);
    do_clear();
    beat(16'd7, 1'b1, w);
    check("clear_sum", 32'(out_sum), 32'd7);
    check("clear_count", 32'(out_count), 32'd1);
    drain();
    beat(16'd0, 1'b0, w);
    beat(16'd0, 1'b1, w);
    drain();

    // Clear while a result is held.
    out_ready = 1'b0;
    beat(16'd10, 1'b0, w);
    beat(16'd20, 1'b0, w);
    beat(16'd30, 1'b1, w);
    do_clear();
    @(negedge clk);
    check("hold_clear_valid", 32'(out_valid), 32'd1);
    check("hold_clear_sum", 32'(out_sum), 32'd60);
    @(posedge clk); #1;
    drain();

    // Randomized traffic with random backpressure and clears.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) do_clear();
      else beat(16'($urandom), ($urandom_range(0, 5) == 0), w);
    end
    for (int i = 0; i < 20; i++) beat(16'($urandom), 1'b0, w);
    beat(16'($urandom), 1'b1, w);
    rand_rdy = 1'b0;
    drain();

    // Reset mid-accumulation, without a clock edge.
    beat(16'd1, 1'b0, w);
    beat(16'd2, 1'b0, w);
    beat(16'd3, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    terms.delete();
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(16'd4, 1'b0, w);
    beat(16'd4, 1'b1, w);
    check("post_rst_sum", 32'(out_sum), 32'd8);
    check("post_rst_count", 32'(out_count), 32'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
